// File: rtl/deque_engine.sv
// deque_engine: circular-buffer double-ended queue.
// Accepts one push/pop at either end per cycle and returns a registered
// response one cycle later. Pushing when full or popping when empty is
// reported through rsp_err and leaves all state untouched.
module deque_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       op_valid,
    input  logic [1:0]                 op_code,
    input  logic [WIDTH-1:0]           op_data,
    output logic                       rsp_valid,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       rsp_err,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Op code bit 1 selects pop (1) or push (0); bit 0 selects front (1) or back (0).
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP,
        ST_ERR,
        ST_CLEAR
    } op_state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_rspValid;
    logic [WIDTH-1:0] r_rspData;
    logic             r_rspErr;

    op_state_t        w_state;
    logic             w_full;
    logic             w_empty;
    logic             w_isPop;
    logic             w_isFront;
    logic [PW-1:0]    w_headDec;
    logic [PW-1:0]    w_headInc;
    logic [PW-1:0]    w_tailDec;
    logic [PW-1:0]    w_tailInc;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_isPop   = op_code[1];
    assign w_isFront = op_code[0];
    assign w_headDec = r_head - PW'(1);
    assign w_headInc = r_head + PW'(1);
    assign w_tailDec = r_tail - PW'(1);
    assign w_tailInc = r_tail + PW'(1);

    // Per-cycle decode of what this cycle does; clear outranks any op.
    always_comb begin
        w_state = ST_IDLE;
        if (clear) begin
            w_state = ST_CLEAR;
        end else if (op_valid) begin
            if (w_isPop) begin
                w_state = w_empty ? ST_ERR : ST_POP;
            end else begin
                w_state = w_full ? ST_ERR : ST_PUSH;
            end
        end
    end

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_state == ST_PUSH) begin
            if (w_isFront) begin
                r_mem[w_headDec] <= op_data;
            end else begin
                r_mem[r_tail] <= op_data;
            end
        end
    end

    // Pointer, occupancy and registered response update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
            r_rspErr   <= 1'b0;
            case (w_state)
                ST_CLEAR: begin
                    r_head  <= '0;
                    r_tail  <= '0;
                    r_count <= '0;
                end
                ST_PUSH: begin
                    r_rspValid <= 1'b1;
                    r_count    <= r_count + CW'(1);
                    if (w_isFront) begin
                        r_head <= w_headDec;
                    end else begin
                        r_tail <= w_tailInc;
                    end
                end
                ST_POP: begin
                    r_rspValid <= 1'b1;
                    r_count    <= r_count - CW'(1);
                    if (w_isFront) begin
                        r_rspData <= r_mem[r_head];
                        r_head    <= w_headInc;
                    end else begin
                        r_rspData <= r_mem[w_tailDec];
                        r_tail    <= w_tailDec;
                    end
                end
                ST_ERR: begin
                    r_rspValid <= 1'b1;
                    r_rspErr   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_data  = r_rspData;
    assign rsp_err   = r_rspErr;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;

endmodule

// File: tb/tb_deque_engine.sv
// tb_deque_engine: table-driven bench for deque_engine (WIDTH=8, DEPTH=4)
// with a scoreboard queue of expected responses and hand-written sequences
// for asynchronous reset.
module tb_deque_engine;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    localparam logic [1:0] OP_PB = 2'b00;
    localparam logic [1:0] OP_PF = 2'b01;
    localparam logic [1:0] OP_OB = 2'b10;
    localparam logic [1:0] OP_OF = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             op_valid;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] op_data;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [2:0]       count;
    logic             full;
    logic             empty;

    typedef struct {
        logic       valid;
        logic       clr;
        logic [1:0] code;
        logic [7:0] data;
        logic       expRspValid;
        logic       expErr;
        logic [7:0] expData;
        int         expCount;
    } vec_t;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } rsp_t;

    vec_t vecs[$];
    rsp_t scoreboard[$];
    int   checks;
    int   failures;

    deque_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .op_valid (op_valid),
        .op_code  (op_code),
        .op_data  (op_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic valid, input logic clr, input logic [1:0] code,
                          input logic [7:0] data, input logic expErr,
                          input logic [7:0] expData, input int expCount);
        vec_t v;
        v.valid       = valid;
        v.clr         = clr;
        v.code        = code;
        v.data        = data;
        v.expRspValid = valid && !clr;
        v.expErr      = expErr;
        v.expData     = expData;
        v.expCount    = expCount;
        vecs.push_back(v);
    endtask

    // Compares flags, count and any response against the scoreboard.
    task automatic checkOutput(input string tag, input logic expRspValid, input int expCount);
        rsp_t e;
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(expRspValid));
        check({tag, " count"}, 32'(count), 32'(expCount));
        check({tag, " full"}, 32'(full), 32'(expCount == DEPTH));
        check({tag, " empty"}, 32'(empty), 32'(expCount == 0));
        if (rsp_valid === 1'b1) begin
            if (scoreboard.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL %s scoreboard: actual=response required=none", tag);
            end else begin
                e = scoreboard.pop_front();
                check({tag, " rsp_data"}, 32'(rsp_data), 32'(e.data));
                check({tag, " rsp_err"}, 32'(rsp_err), 32'(e.err));
            end
        end
        scoreboard.delete();
    endtask

    // Drives one cycle of inputs at the falling edge and checks after the rising edge.
    task automatic applyStimulus(input string tag, input vec_t v);
        rsp_t e;
        @(negedge clk);
        op_valid = v.valid;
        clear    = v.clr;
        op_code  = v.code;
        op_data  = v.data;
        if (v.expRspValid) begin
            e.err  = v.expErr;
            e.data = v.expData;
            scoreboard.push_back(e);
        end
        @(posedge clk);
        #1;
        checkOutput(tag, v.expRspValid, v.expCount);
    endtask

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        op_valid = 1'b0;
        op_code  = 2'b00;
        op_data  = '0;

        // FIFO order: push_back x3 then pop_front x3
        addVec(1, 0, OP_PB, 8'h11, 0, 8'h00, 1);
        addVec(1, 0, OP_PB, 8'h22, 0, 8'h00, 2);
        addVec(1, 0, OP_PB, 8'h33, 0, 8'h00, 3);
        addVec(1, 0, OP_OF, 8'h00, 0, 8'h11, 2);
        addVec(1, 0, OP_OF, 8'h00, 0, 8'h22, 1);
        addVec(1, 0, OP_OF, 8'h00, 0, 8'h33, 0);
        addVec(0, 0, OP_PB, 8'hEE, 0, 8'h00, 0);
        // Pointer wrap at the front and back ends
        addVec(0, 1, OP_PB, 8'h00, 0, 8'h00, 0);
        addVec(1, 0, OP_PF, 8'hA1, 0, 8'h00, 1);
        addVec(1, 0, OP_PF, 8'hA2, 0, 8'h00, 2);
        addVec(1, 0, OP_OF, 8'h00, 0, 8'hA2, 1);
        addVec(1, 0, OP_OB, 8'h00, 0, 8'hA1, 0);
        // Fill, overflow, then drain from both ends
        addVec(1, 0, OP_PB, 8'h01, 0, 8'h00, 1);
        addVec(1, 0, OP_PB, 8'h02, 0, 8'h00, 2);
        addVec(1, 0, OP_PB, 8'h03, 0, 8'h00, 3);
        addVec(1, 0, OP_PB, 8'h04, 0, 8'h00, 4);
        addVec(1, 0, OP_PB, 8'h55, 1, 8'h00, 4);
        addVec(1, 0, OP_PF, 8'h66, 1, 8'h00, 4);
        addVec(1, 0, OP_OB, 8'h00, 0, 8'h04, 3);
        addVec(1, 0, OP_OF, 8'h00, 0, 8'h01, 2);
        addVec(1, 0, OP_OF, 8'h00, 0, 8'h02, 1);
        addVec(1, 0, OP_OF, 8'h00, 0, 8'h03, 0);
        // Underflow, then recovery
        addVec(1, 0, OP_OF, 8'h00, 1, 8'h00, 0);
        addVec(1, 0, OP_OB, 8'h00, 1, 8'h00, 0);
        addVec(1, 0, OP_PB, 8'h77, 0, 8'h00, 1);
        addVec(1, 0, OP_OB, 8'h00, 0, 8'h77, 0);
        // LIFO through the front and mixing ends
        addVec(1, 0, OP_PF, 8'hB1, 0, 8'h00, 1);
        addVec(1, 0, OP_PB, 8'hB2, 0, 8'h00, 2);
        addVec(1, 0, OP_PF, 8'hB3, 0, 8'h00, 3);
        addVec(1, 0, OP_OF, 8'h00, 0, 8'hB3, 2);
        addVec(1, 0, OP_OB, 8'h00, 0, 8'hB2, 1);
        addVec(1, 0, OP_OB, 8'h00, 0, 8'hB1, 0);
        // Clear beats a simultaneous push
        addVec(1, 0, OP_PB, 8'h10, 0, 8'h00, 1);
        addVec(1, 0, OP_PB, 8'h20, 0, 8'h00, 2);
        addVec(1, 1, OP_PB, 8'h30, 0, 8'h00, 0);
        addVec(1, 0, OP_OF, 8'h00, 1, 8'h00, 0);

        // Reset state while reset is held
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 0);
        check("reset rsp_data", 32'(rsp_data), 32'h0);
        check("reset rsp_err", 32'(rsp_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset between edges drops a pending response
        addVec(1, 0, OP_PB, 8'hC1, 0, 8'h00, 1);
        applyStimulus("arst push1", vecs[vecs.size()-1]);
        @(negedge clk);
        op_valid = 1'b1;
        clear    = 1'b0;
        op_code  = OP_PB;
        op_data  = 8'hC2;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst rsp_valid", 32'(rsp_valid), 32'h0);
        check("arst count", 32'(count), 32'h0);
        check("arst empty", 32'(empty), 32'h1);
        check("arst rsp_data", 32'(rsp_data), 32'h0);
        scoreboard.delete();
        @(negedge clk);
        op_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("arst release", 1'b0, 0);
        v.valid       = 1'b1;
        v.clr         = 1'b0;
        v.code        = OP_OF;
        v.data        = 8'h00;
        v.expRspValid = 1'b1;
        v.expErr      = 1'b1;
        v.expData     = 8'h00;
        v.expCount    = 0;
        applyStimulus("arst underflow", v);
        v.valid       = 1'b0;
        v.expRspValid = 1'b0;
        v.expErr      = 1'b0;
        applyStimulus("final idle", v);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
